// File: rtl/stm_focus_writer_pkg.sv
// Shared definitions for the focus-STM memory: FSM state type and the 64-bit
// entry field layout that both the writer and the focus-STM reader rely on.
package stm_pkg;

  localparam logic [1:0] ST_COLLECT = 2'd0;
  localparam logic [1:0] ST_WRITE   = 2'd1;
  localparam logic [1:0] ST_FULL    = 2'd2;

  typedef enum logic [1:0] {
    COLLECT = ST_COLLECT,
    WRITE   = ST_WRITE,
    FULL    = ST_FULL
  } state_t;

  localparam int FocusHwPerEntry = 4;

  localparam int X_LSB    = 0;
  localparam int X_W      = 18;
  localparam int Y_LSB    = 18;
  localparam int Y_W      = 18;
  localparam int Z_LSB    = 36;
  localparam int Z_W      = 18;
  localparam int INT_LSB  = 54;
  localparam int INT_W    = 8;
  localparam int RSVD_LSB = 62;
  localparam int RSVD_W   = 2;

  // Rebuilds an entry field by field so the reserved bits never carry host data.
  function automatic logic [63:0] pack_entry(input logic [63:0] raw);
    logic [63:0] e;
    e = '0;
    e[X_LSB   +: X_W]    = raw[X_LSB   +: X_W];
    e[Y_LSB   +: Y_W]    = raw[Y_LSB   +: Y_W];
    e[Z_LSB   +: Z_W]    = raw[Z_LSB   +: Z_W];
    e[INT_LSB +: INT_W]  = raw[INT_LSB +: INT_W];
    e[RSVD_LSB +: RSVD_W] = '0;
    return e;
  endfunction

endpackage

// File: rtl/stm_focus_writer_if.sv
// Halfword stream from the host path into the focus-STM writer.
interface stm_focus_writer_if;

  logic        IN_VALID;
  logic        IN_READY;
  logic [15:0] IN_DATA;
  logic        IN_LAST;

  modport master (output IN_VALID, IN_DATA, IN_LAST, input IN_READY);
  modport slave  (input IN_VALID, IN_DATA, IN_LAST, output IN_READY);

endinterface

// File: rtl/stm_focus_writer.sv
// Packs four host halfwords into one 64-bit focus entry and writes it to the
// focus STM BRAM at sequential addresses, tracking count and error flags.
//
// state   | meaning
// COLLECT | gathering halfwords of the current entry
// WRITE   | entry on the BRAM bus this cycle, input stalled
// FULL    | BRAM full, input drained and flagged until CLEAR/reset
module stm_focus_writer
  import stm_pkg::*;
#(
  parameter int  DEPTH = 8192,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                      CLK,
  input  logic                      RESETN,
  input  logic                      CLEAR,
  stm_focus_writer_if.slave         s_in,
  output logic                      BRAM_WE,
  output logic [AW-1:0]             BRAM_ADDR,
  output logic [63:0]               BRAM_DIN,
  output logic [AW:0]               COUNT,
  output logic                      DONE,
  output logic                      ERR_OVERFLOW,
  output logic                      ERR_PARTIAL
);

  localparam logic [AW:0] PTR_FULL = (AW + 1)'(DEPTH);
  localparam logic [1:0]  LAST_HW  = 2'(FocusHwPerEntry - 1);

  state_t      state;
  logic [1:0]  hw_idx;
  logic [47:0] low_q;
  logic [AW:0] ptr;
  logic        ready;
  logic        accept;

  assign ready          = (state != WRITE);
  assign s_in.IN_READY  = ready;
  assign accept         = s_in.IN_VALID && ready;
  assign COUNT          = ptr;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state        <= COLLECT;
      hw_idx       <= '0;
      low_q        <= '0;
      ptr          <= '0;
      BRAM_WE      <= 1'b0;
      BRAM_ADDR    <= '0;
      BRAM_DIN     <= '0;
      DONE         <= 1'b0;
      ERR_OVERFLOW <= 1'b0;
      ERR_PARTIAL  <= 1'b0;
    end else begin
      BRAM_WE <= 1'b0;
      DONE    <= 1'b0;
      if (CLEAR) begin
        // address/data are left alone; a write already on the bus completes
        state        <= COLLECT;
        hw_idx       <= '0;
        ptr          <= '0;
        ERR_OVERFLOW <= 1'b0;
        ERR_PARTIAL  <= 1'b0;
      end else begin
        unique case (state)
          COLLECT: begin
            if (accept) begin
              if (hw_idx == LAST_HW) begin
                BRAM_WE   <= 1'b1;
                BRAM_ADDR <= ptr[AW-1:0];
                BRAM_DIN  <= pack_entry({s_in.IN_DATA, low_q});
                ptr       <= ptr + (AW + 1)'(1);
                hw_idx    <= '0;
                state     <= WRITE;
                DONE      <= s_in.IN_LAST;
              end else if (s_in.IN_LAST) begin
                hw_idx      <= '0;
                ERR_PARTIAL <= 1'b1;
                DONE        <= 1'b1;
              end else begin
                case (hw_idx)
                  2'd0:    low_q[15:0]  <= s_in.IN_DATA;
                  2'd1:    low_q[31:16] <= s_in.IN_DATA;
                  default: low_q[47:32] <= s_in.IN_DATA;
                endcase
                hw_idx <= hw_idx + 2'd1;
              end
            end
          end
          WRITE: begin
            state <= (ptr == PTR_FULL) ? FULL : COLLECT;
          end
          FULL: begin
            if (accept) begin
              ERR_OVERFLOW <= 1'b1;
              DONE         <= s_in.IN_LAST;
            end
          end
          default: state <= COLLECT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stm_focus_writer.sv
// Self-checking bench for stm_focus_writer (DEPTH=4): directed table, corner
// sequences and randomized traffic against a transfer-level reference model.
module tb_stm_focus_writer;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          CLK = 1'b0;
  logic          RESETN;
  logic          CLEAR;
  logic          BRAM_WE;
  logic [AW-1:0] BRAM_ADDR;
  logic [63:0]   BRAM_DIN;
  logic [AW:0]   COUNT;
  logic          DONE;
  logic          ERR_OVERFLOW;
  logic          ERR_PARTIAL;

  stm_focus_writer_if s_if ();

  stm_focus_writer #(.DEPTH(DEPTH)) dut (
    .CLK          (CLK),
    .RESETN       (RESETN),
    .CLEAR        (CLEAR),
    .s_in         (s_if),
    .BRAM_WE      (BRAM_WE),
    .BRAM_ADDR    (BRAM_ADDR),
    .BRAM_DIN     (BRAM_DIN),
    .COUNT        (COUNT),
    .DONE         (DONE),
    .ERR_OVERFLOW (ERR_OVERFLOW),
    .ERR_PARTIAL  (ERR_PARTIAL)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_err    = 0;
  int rdy_low_cnt;
  int we_cnt;

  // reference model: the current entry is a queue of halfwords
  logic        m_we, m_done, m_eov, m_epart, m_busy;
  logic [1:0]  m_addr;
  logic [63:0] m_din;
  int          m_count;
  logic [15:0] m_cur[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_we = 0; m_done = 0; m_eov = 0; m_epart = 0; m_busy = 0;
    m_addr = 0; m_din = 0; m_count = 0;
    m_cur.delete();
  endtask

  task automatic model_step(input logic clr, input logic vld, input logic [15:0] d,
                            input logic lst, output logic acc);
    acc    = vld && !m_busy && !clr;
    m_we   = 0;
    m_done = 0;
    if (clr) begin
      m_count = 0; m_eov = 0; m_epart = 0; m_busy = 0;
      m_cur.delete();
    end else if (m_busy) begin
      m_busy = 0;
    end else if (m_count == DEPTH) begin
      if (acc) begin
        m_eov  = 1;
        m_done = lst;
      end
    end else if (acc) begin
      m_cur.push_back(d);
      if (m_cur.size() == 4) begin
        m_we    = 1;
        m_addr  = 2'(m_count);
        m_din   = {2'b00, m_cur[3][13:0], m_cur[2], m_cur[1], m_cur[0]};
        m_count = m_count + 1;
        m_busy  = 1;
        m_done  = lst;
        m_cur.delete();
      end else if (lst) begin
        m_cur.delete();
        m_epart = 1;
        m_done  = 1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    if (s_if.IN_READY === 1'b0) rdy_low_cnt++;
    if (BRAM_WE === 1'b1) we_cnt++;
    chk({tag, "/ready"}, 64'(s_if.IN_READY), 64'(!m_busy));
    chk({tag, "/we"},    64'(BRAM_WE),       64'(m_we));
    chk({tag, "/addr"},  64'(BRAM_ADDR),     64'(m_addr));
    chk({tag, "/din"},   BRAM_DIN,           m_din);
    chk({tag, "/count"}, 64'(COUNT),         64'(m_count));
    chk({tag, "/done"},  64'(DONE),          64'(m_done));
    chk({tag, "/eovf"},  64'(ERR_OVERFLOW),  64'(m_eov));
    chk({tag, "/epart"}, 64'(ERR_PARTIAL),   64'(m_epart));
  endtask

  task automatic apply(input logic clr, input logic vld, input logic [15:0] d,
                       input logic lst, output logic acc);
    CLEAR         = clr;
    s_if.IN_VALID = vld;
    s_if.IN_DATA  = d;
    s_if.IN_LAST  = lst;
    model_step(clr, vld, d, lst, acc);
    @(posedge CLK);
    #1;
    CLEAR         = 1'b0;
    s_if.IN_VALID = 1'b0;
    s_if.IN_LAST  = 1'b0;
  endtask

  task automatic do_reset();
    logic a;
    CLEAR         = 1'b0;
    s_if.IN_VALID = 1'b0;
    s_if.IN_LAST  = 1'b0;
    s_if.IN_DATA  = '0;
    RESETN        = 1'b0;
    model_reset();
    #2;
    check_all("reset");
    @(negedge CLK);
    RESETN = 1'b1;
    apply(1'b0, 1'b0, 16'h0, 1'b0, a);
    check_all("post_reset");
  endtask

  task automatic send_hw(input string tag, input logic [15:0] d, input logic lst);
    logic a;
    a = 1'b0;
    for (int k = 0; k < 8 && !a; k++) begin
      apply(1'b0, 1'b1, d, lst, a);
      check_all(tag);
    end
    if (!a) chk({tag, "/hs_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic idle(input string tag, input logic clr);
    logic a;
    apply(clr, 1'b0, 16'h0, 1'b0, a);
    check_all(tag);
  endtask

  typedef struct {
    logic        clr, vld, lst;
    logic [15:0] d;
    logic        we;
    logic [1:0]  addr;
    logic [63:0] din;
    int          cnt;
    logic        done, rdy;
  } vec_t;

  localparam logic [63:0] ENT = 64'h3FC1_000F_FC00_0100;

  vec_t tbl[11];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic a, clr, vld, lst;
    logic [15:0] d;
    int r;

    tbl[0]  = '{1'b0, 1'b1, 1'b0, 16'h0100, 1'b0, 2'd0, 64'd0, 0, 1'b0, 1'b1};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 16'hFC00, 1'b0, 2'd0, 64'd0, 0, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 16'h000F, 1'b0, 2'd0, 64'd0, 0, 1'b0, 1'b1};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 16'h3FC1, 1'b1, 2'd0, ENT,   1, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 2'd0, ENT,   1, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 16'h0100, 1'b0, 2'd0, ENT,   1, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 16'hFC00, 1'b0, 2'd0, ENT,   1, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 16'h000F, 1'b0, 2'd0, ENT,   1, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 16'hFFC1, 1'b1, 2'd1, ENT,   2, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 2'd1, ENT,   2, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 2'd1, ENT,   0, 1'b0, 1'b1};

    CLEAR = 1'b0; s_if.IN_VALID = 1'b0; s_if.IN_LAST = 1'b0; s_if.IN_DATA = '0;
    rdy_low_cnt = 0; we_cnt = 0;
    do_reset();

    // single entry, then reserved bits forced low on a second entry
    for (int i = 0; i < 11; i++) begin
      apply(tbl[i].clr, tbl[i].vld, tbl[i].d, tbl[i].lst, a);
      chk($sformatf("tbl%0d/we", i),    64'(BRAM_WE),        64'(tbl[i].we));
      chk($sformatf("tbl%0d/addr", i),  64'(BRAM_ADDR),      64'(tbl[i].addr));
      chk($sformatf("tbl%0d/din", i),   BRAM_DIN,            tbl[i].din);
      chk($sformatf("tbl%0d/count", i), 64'(COUNT),          64'(tbl[i].cnt));
      chk($sformatf("tbl%0d/done", i),  64'(DONE),           64'(tbl[i].done));
      chk($sformatf("tbl%0d/ready", i), 64'(s_if.IN_READY),  64'(tbl[i].rdy));
    end

    // backpressure: 12 halfwords with IN_VALID held high
    rdy_low_cnt = 0; we_cnt = 0;
    for (int i = 0; i < 12; i++) send_hw("bp", 16'(16'h1000 + i), 1'b0);
    idle("bp_tail", 1'b0);
    chk("bp/ready_low_cycles", 64'(rdy_low_cnt), 64'd3);
    chk("bp/writes", 64'(we_cnt), 64'd3);
    chk("bp/count", 64'(COUNT), 64'd3);

    // partial transfer: LAST on the 6th halfword
    idle("part_clr", 1'b1);
    for (int i = 0; i < 6; i++) send_hw("part", 16'(16'h2000 + i), i == 5);
    chk("part/epart", 64'(ERR_PARTIAL), 64'd1);
    chk("part/done", 64'(DONE), 64'd1);
    chk("part/count", 64'(COUNT), 64'd1);
    for (int i = 0; i < 4; i++) send_hw("part2", 16'(16'h2100 + i), 1'b0);
    chk("part2/we", 64'(BRAM_WE), 64'd1);
    chk("part2/addr", 64'(BRAM_ADDR), 64'd1);

    // overflow: five entries into a four-deep memory
    idle("ovf_clr", 1'b1);
    we_cnt = 0;
    for (int i = 0; i < 20; i++) send_hw("ovf", 16'($urandom), i == 19);
    chk("ovf/done_in_full", 64'(DONE), 64'd1);
    chk("ovf/writes", 64'(we_cnt), 64'd4);
    chk("ovf/count", 64'(COUNT), 64'd4);
    chk("ovf/eovf", 64'(ERR_OVERFLOW), 64'd1);
    idle("ovf_clr2", 1'b1);
    chk("ovf_clr/count", 64'(COUNT), 64'd0);
    chk("ovf_clr/eovf", 64'(ERR_OVERFLOW), 64'd0);
    for (int i = 0; i < 4; i++) send_hw("ovf_re", 16'(16'h3000 + i), 1'b0);
    chk("ovf_re/we", 64'(BRAM_WE), 64'd1);
    chk("ovf_re/addr", 64'(BRAM_ADDR), 64'd0);

    // CLEAR arriving while the entry is on the bus
    idle("cw_clr", 1'b1);
    for (int i = 0; i < 4; i++) send_hw("cw", 16'(16'h4000 + i), 1'b0);
    chk("cw/we_before_clear", 64'(BRAM_WE), 64'd1);
    idle("cw_clear", 1'b1);
    chk("cw/count", 64'(COUNT), 64'd0);

    // async reset mid-entry
    send_hw("rst_mid", 16'hABCD, 1'b0);
    send_hw("rst_mid", 16'h1234, 1'b0);
    do_reset();
    send_hw("rst_after", 16'h1111, 1'b0);
    send_hw("rst_after", 16'h2222, 1'b0);
    send_hw("rst_after", 16'h3333, 1'b0);
    send_hw("rst_after", 16'h4444, 1'b0);
    chk("rst_after/we", 64'(BRAM_WE), 64'd1);
    chk("rst_after/addr", 64'(BRAM_ADDR), 64'd0);
    chk("rst_after/din", BRAM_DIN, 64'h0444_3333_2222_1111);

    // randomized traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 999));
      if (r < 5) begin
        do_reset();
      end else begin
        clr = (r < 25);
        vld = ($urandom_range(0, 9) < 7);
        lst = ($urandom_range(0, 9) == 0);
        d   = 16'($urandom);
        apply(clr, vld, d, lst, a);
        check_all("rnd");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/stm_focus_writer.md
Name: stm_focus_writer

Overview:
Write side of the focus-STM memory. It accepts a 16-bit halfword stream from the CPU-bus/host path and packs each group of four halfwords into one 64-bit focus entry. Each entry is written into the focus STM BRAM at sequential addresses, using the field layout that the focus-STM reader consumes. It also tracks the entry count and flags overflow and truncated transfers.

Parameters:
DEPTH, 8192, maximum focus entries (BRAM depth); AW = $clog2(DEPTH) is derived.

Ports:
CLK  in  1  system clock
RESETN  in  1  asynchronous active-low reset
CLEAR  in  1  synchronous restart: pointer and errors to 0
IN_VALID  in  1  halfword valid
IN_READY  out  1  halfword accepted when IN_VALID & IN_READY
IN_DATA  in  16  halfword, least-significant first
IN_LAST  in  1  marks the final halfword of a transfer
BRAM_WE  out  1  focus BRAM write enable
BRAM_ADDR  out  AW  focus BRAM write address
BRAM_DIN  out  64  packed focus entry
COUNT  out  AW+1  number of entries written
DONE  out  1  one-cycle pulse at the end of a transfer
ERR_OVERFLOW  out  1  sticky: data arrived while full
ERR_PARTIAL  out  1  sticky: IN_LAST arrived mid-entry

Behaviour:
- Reset (RESETN low, async): BRAM_WE=0, BRAM_ADDR=0, BRAM_DIN=0, COUNT=0, DONE=0, both errors 0, hw_idx=0, state=COLLECT.
- IN_READY is combinational: 0 only in WRITE, otherwise 1 (so it reads 1 during reset).
- Entry layout (bit ranges):
  - 17:0 x (signed)
  - 35:18 y (signed)
  - 53:36 z (signed)
  - 61:54 intensity
  - 63:62 reserved, forced to 0 regardless of input
- Halfword k (k=0..3) fills BRAM_DIN bits 16k+15:16k.
- States:
  - COLLECT, on each accepted halfword:
    - Store the halfword at hw_idx.
    - If hw_idx<3, increment hw_idx.
    - If hw_idx==3, register BRAM_WE=1, BRAM_ADDR=ptr and BRAM_DIN=assembled entry; set ptr=ptr+1, hw_idx=0, state=WRITE.
  - WRITE: exactly one cycle, BRAM_WE=1 visible. Next cycle BRAM_WE=0; state=FULL if ptr==DEPTH, else COLLECT.
  - FULL: IN_READY=1, and accepted halfwords are dropped and set ERR_OVERFLOW. Leaves FULL only on CLEAR or reset.
- Latency: 4th halfword accepted in cycle t, BRAM_WE high in cycle t+1, COUNT=ptr (new value) from t+1. Throughput is 4 halfwords per 5 cycles.
- IN_LAST:
  - With hw_idx==3: normal write; DONE pulses in the WRITE cycle.
  - With hw_idx<3: the partial entry is discarded, hw_idx=0, ERR_PARTIAL set, DONE pulses the next cycle. No write occurs.
  - IN_LAST is ignored unless the halfword is accepted.
- In FULL, an accepted IN_LAST produces DONE next cycle and sets ERR_OVERFLOW.
- No wrap-around: ptr saturates at DEPTH, and COUNT width holds DEPTH.
- CLEAR has priority over all other updates:
  - ptr=0, hw_idx=0, errors=0, state=COLLECT, DONE=0.
  - A halfword presented with CLEAR is not captured.
  - CLEAR during WRITE: that cycle's BRAM write still occurs (WE is already on the bus), and COUNT reads 0 afterwards.
- Reset mid-entry: partial data is lost and the pointer returns to 0.

Decomposition:
- Package stm_pkg holds:
  - state_t enum {COLLECT, WRITE, FULL}
  - localparam FocusHwPerEntry=4
  - field offsets/widths for x, y, z, intensity and reserved, shared with the focus-STM reader
- No sub-module; the block is a single FSM plus assembly registers.

Test Plan:
- Single entry: halfwords 0x0100, 0xFC00, 0x000F, 0x3FC1 with LAST on the 4th → one WE with ADDR=0 and DIN=0x3FC1_000F_FC00_0100 (x=0x100, y=-256, z=0x1000, intensity=0xFF). DONE and WE occur in the same cycle; COUNT=1.
- Reserved forcing: same stream but 4th halfword 0xFFC1 → DIN=0x3FC1_000F_FC00_0100.
- Backpressure: continuous IN_VALID for 3 entries (12 halfwords) → IN_READY low exactly one cycle after each 4th halfword. ADDR sequence is 0,1,2; COUNT=3; no halfword lost.
- Partial: 6 halfwords with LAST on the 6th → one write at ADDR 0, ERR_PARTIAL=1, DONE one cycle after the 6th, COUNT=1. The next 4 halfwords are written to ADDR 1.
- Overflow (DEPTH=4): 5 entries sent → writes to ADDR 0..3, COUNT=4, state FULL, no 5th write, ERR_OVERFLOW=1. CLEAR → COUNT=0 and errors=0, and the next entry is written to ADDR 0.
- Async reset after 2 halfwords, then 4 halfwords → first write at ADDR 0 containing only the post-reset halfwords.
